key_event_gen: RTL and testbench
================================

# key_event_gen

Parametrised, multi-channel key-event generator for the synthesizer's note/control inputs. Each of `N` channels debounces a raw level input and converts it into a one-cycle press pulse, a one-cycle release pulse, a held level, and optional auto-repeat press pulses. It sits between the switch/key synchronisers and the note-trigger and menu logic. It replaces single-channel edge-to-pulse conversion wherever bounce rejection or auto-repeat is needed.

## Interface
- `N`, 8 — number of independent channels.
- `DEBOUNCE`, 500000 — consecutive samples a new level must persist before it is accepted; ≥1.
- `REPEAT_DELAY`, 25000000 — cycles from the initial press pulse to the first repeat pulse; ≥2.
- `REPEAT_PERIOD`, 5000000 — cycles between subsequent repeat pulses; ≥2.
- `Clk`  in  1 — the single clock; all logic is on the rising edge.
- `Reset`  in  1 — synchronous, active-high.
- `data`  in  N — raw key levels, already synchronised to `Clk`; 1 = pressed.
- `repeat_en`  in  1 — global auto-repeat enable.
- `press_out`  out  N — one-cycle pulse on an accepted press and on each repeat.
- `release_out`  out  N — one-cycle pulse on an accepted release.
- `held_out`  out  N — 1 while the channel is in HIGH, HOLD or RPT.

## Operation
- Channels are fully independent. There is no arbitration, and any mix of channels may pulse in the same cycle.
- Debounce, per channel:
  - Registered level `deb` (reset 0) and counter `dcnt`.
  - Each edge: if `data[i]==deb`, then `dcnt<=0`.
  - Otherwise, if `dcnt==DEBOUNCE-1`, then `deb<=data[i]` and `dcnt<=0`.
  - Otherwise `dcnt++`.
  - Any single agreeing sample restarts the count.
- FSM per channel, states WAIT, HIGH, HOLD, RPT, REL:
  - WAIT: `deb=1` → HIGH; otherwise stay.
  - HIGH: lasts exactly one cycle. `deb=1` → HOLD; `deb=0` → REL.
  - HOLD: `deb=0` → REL. Otherwise, when `repeat_en=1` and the repeat count expires → RPT. Otherwise stay.
  - RPT: lasts exactly one cycle. `deb=1` → HOLD; `deb=0` → REL.
  - REL: lasts exactly one cycle, then → WAIT unconditionally. A re-press is detected from WAIT.
- Outputs are Moore, decoded from the state:
  - `press_out` = HIGH or RPT.
  - `release_out` = REL.
  - `held_out` = HIGH, HOLD or RPT.
- Repeat counter, per channel:
  - Counts cycles since the last press pulse (HIGH or RPT).
  - The first expiry threshold is `REPEAT_DELAY`; after that it is `REPEAT_PERIOD`.
  - It is cleared, and the first-repeat flag reset, whenever `repeat_en=0` or the state is WAIT/REL.
  - Re-enabling mid-hold therefore restarts the full `REPEAT_DELAY`.
- Counter widths are `$clog2(param+1)`. No counter may wrap, and all counters saturate by construction.

## Timing
- Reset: all states WAIT; `deb`, `dcnt` and repeat counters are 0; `press_out`, `release_out` and `held_out` are all 0 in the cycle after the reset edge.
- Press latency: with `data[i]` first sampled high at edge e1 and held, `deb` rises after edge e`DEBOUNCE`. `press_out[i]` is then high for exactly the cycle after edge e`DEBOUNCE+1`.
- Release latency has the same structure: `release_out[i]` goes high `DEBOUNCE+1` edges after the first low sample.
- Repeat spacing, measured rising-edge to rising-edge of `press_out[i]`:
  - Initial press to first repeat: exactly `REPEAT_DELAY` cycles.
  - Between later repeats: exactly `REPEAT_PERIOD` cycles.
- Release wins over repeat: if `deb` falls in the same cycle that the repeat would expire, the next state is REL and no RPT pulse is issued.
- A key held across reset deassertion is treated as a fresh press, with `press_out` at the normal latency.
- Reset asserted mid-HOLD or mid-RPT returns the channel to WAIT at the next edge, with no release pulse.

## Test plan
Bench parameters: `N=4`, `DEBOUNCE=3`, `REPEAT_DELAY=10`, `REPEAT_PERIOD=4`.
- **Clean press/release:** `data[0]` rises and holds for 20 cycles with `repeat_en=0` → `press_out[0]` high for 1 cycle exactly 4 edges after the first high sample; `held_out[0]` stays high until release; on the fall, `release_out[0]` is 1 cycle wide 4 edges later.
- **Bounce rejection:** `data[1]` pattern 1,1,0,1,1,0,1,1,1 → exactly one `press_out[1]`, occurring 4 edges after the final run of 1s starts; no release pulse.
- **Auto-repeat:** `repeat_en=1` and `data[2]` held for 30 cycles → `press_out[2]` pulses at t, t+10, t+14, t+18, …; one `release_out[2]` after the fall; no press pulse after the release.
- **Release/repeat collision:** `data[2]` falls so that `deb` drops in the repeat-expiry cycle → REL is taken and no extra press pulse occurs.
- **Independence:** all four channels pressed simultaneously → four simultaneous press pulses; one channel releasing does not disturb `held_out` on the others.
- **Reset behaviour:** `Reset` pulsed mid-HOLD on channel 3 with the key still down → all outputs 0 next cycle and no release pulse; a fresh `press_out[3]` follows 4 edges after reset deasserts.

Source files
------------

// File: rtl/key_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : key_event_gen                                              |
// | Description : Multi-channel key-event generator. Each channel debounces  |
// |               a raw key level and turns it into a one-cycle press pulse, |
// |               a one-cycle release pulse, a held level and optional       |
// |               auto-repeat press pulses.                                  |
// | Ports       : Clk         - single clock, rising edge                    |
// |               Reset       - synchronous, active-high                     |
// |               data[N]     - synchronised raw key levels (1 = pressed)    |
// |               repeat_en   - global auto-repeat enable                    |
// |               press_out   - pulse on accepted press and on each repeat   |
// |               release_out - pulse on accepted release                    |
// |               held_out    - high while the key is considered down        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module key_event_gen #(
    parameter int N             = 8,
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] data,
    input  logic         repeat_en,
    output logic [N-1:0] press_out,
    output logic [N-1:0] release_out,
    output logic [N-1:0] held_out
);

    localparam int c_DW   = $clog2(DEBOUNCE + 1);
    localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RW   = $clog2(c_RMAX + 1);

    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEBOUNCE - 1);
    localparam logic [c_DW-1:0] c_DCNT_ONE  = c_DW'(1);
    localparam logic [c_RW-1:0] c_DLY_LAST  = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_PER_LAST  = c_RW'(REPEAT_PERIOD - 1);
    localparam logic [c_RW-1:0] c_RCNT_ONE  = c_RW'(1);

    localparam logic [2:0] c_S_WAIT = 3'd0;
    localparam logic [2:0] c_S_HIGH = 3'd1;
    localparam logic [2:0] c_S_HOLD = 3'd2;
    localparam logic [2:0] c_S_RPT  = 3'd3;
    localparam logic [2:0] c_S_REL  = 3'd4;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic            r_deb;
        logic [c_DW-1:0] r_dcnt;
        logic [2:0]      r_state;
        logic [2:0]      w_next;
        logic [c_RW-1:0] r_rcnt;
        logic            r_rpt_seen;
        logic            w_expire;
        logic            r_press;
        logic            r_release;
        logic            r_held;

        // r_rcnt holds the number of cycles since the last press pulse, so the
        // transition into RPT is taken one count before the threshold and the
        // RPT cycle lands exactly REPEAT_DELAY / REPEAT_PERIOD after it.
        assign w_expire = repeat_en &&
                          (r_rcnt == (r_rpt_seen ? c_PER_LAST : c_DLY_LAST));

        always_comb begin
            w_next = r_state;
            case (r_state)
                c_S_WAIT: if (r_deb) w_next = c_S_HIGH;
                c_S_HIGH: w_next = r_deb ? c_S_HOLD : c_S_REL;
                c_S_HOLD: begin
                    // A falling level takes priority over a repeat expiry.
                    if (!r_deb)        w_next = c_S_REL;
                    else if (w_expire) w_next = c_S_RPT;
                end
                c_S_RPT:  w_next = r_deb ? c_S_HOLD : c_S_REL;
                c_S_REL:  w_next = c_S_WAIT;
                default:  w_next = c_S_WAIT;
            endcase
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_deb      <= 1'b0;
                r_dcnt     <= '0;
                r_state    <= c_S_WAIT;
                r_rcnt     <= '0;
                r_rpt_seen <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_held     <= 1'b0;
            end else begin
                // Debounce: any agreeing sample restarts the persistence count.
                if (data[gi] == r_deb) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == c_DEB_LAST) begin
                    r_deb  <= data[gi];
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + c_DCNT_ONE;
                end

                r_state   <= w_next;
                // Outputs are decoded from the next state so they line up
                // with the state register they describe.
                r_press   <= (w_next == c_S_HIGH) || (w_next == c_S_RPT);
                r_release <= (w_next == c_S_REL);
                r_held    <= (w_next == c_S_HIGH) || (w_next == c_S_HOLD) ||
                             (w_next == c_S_RPT);

                // Repeat timing. Disabling repeat clears the count, so
                // re-enabling mid-hold restarts the full initial delay.
                if (!repeat_en || (r_state == c_S_WAIT) || (r_state == c_S_REL)) begin
                    r_rcnt     <= '0;
                    r_rpt_seen <= 1'b0;
                end else if ((r_state == c_S_HIGH) || (r_state == c_S_RPT)) begin
                    r_rcnt <= c_RCNT_ONE;
                    if (r_state == c_S_RPT) r_rpt_seen <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + c_RCNT_ONE;
                end
            end
        end

        assign press_out[gi]   = r_press;
        assign release_out[gi] = r_release;
        assign held_out[gi]    = r_held;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_key_event_gen                                           |
// | Description : Self-checking bench for key_event_gen. Stimulus pushes the |
// |               expected per-cycle outputs from a timestamp-based model    |
// |               into a queue; an independent monitor pops and compares.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_key_event_gen;

    localparam int N  = 4;
    localparam int D  = 3;
    localparam int RD = 10;
    localparam int RP = 4;

    logic         clk;
    logic         Reset;
    logic [N-1:0] data;
    logic         repeat_en;
    logic [N-1:0] press_out;
    logic [N-1:0] release_out;
    logic [N-1:0] held_out;

    key_event_gen #(
        .N            (N),
        .DEBOUNCE     (D),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) u_dut (
        .Clk        (clk),
        .Reset      (Reset),
        .data       (data),
        .repeat_en  (repeat_en),
        .press_out  (press_out),
        .release_out(release_out),
        .held_out   (held_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int           cyc;
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] h;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: accepted level via a count of disagreeing samples, and
    // key episodes described by absolute cycle numbers of the next repeat.
    int   k = 0;
    int   run   [N];
    bit   mdeb  [N];
    bit   held  [N];
    bit   relc  [N];
    int   nrpt  [N];
    logic [N-1:0] cur;
    logic         en_cur;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            run[i] = 0; mdeb[i] = 1'b0; held[i] = 1'b0; relc[i] = 1'b0; nrpt[i] = 0;
        end
    endtask

    task automatic step(input logic [N-1:0] d, input logic en, input logic rst);
        exp_t e;
        bit   dprev;
        @(negedge clk);
        data = d; repeat_en = en; Reset = rst;
        k++;
        e.cyc = k; e.p = '0; e.r = '0; e.h = '0;
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                dprev = mdeb[i];
                if (relc[i]) begin
                    relc[i] = 1'b0;
                end else if (!held[i]) begin
                    if (dprev) begin
                        held[i] = 1'b1; e.p[i] = 1'b1; nrpt[i] = k + RD;
                    end
                end else if (!dprev) begin
                    held[i] = 1'b0; relc[i] = 1'b1; e.r[i] = 1'b1;
                end else if (en && k == nrpt[i]) begin
                    e.p[i] = 1'b1; nrpt[i] = k + RP;
                end
                if (held[i] && !en) nrpt[i] = k + RD;
                e.h[i] = held[i];
                if (d[i] == mdeb[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == D) begin mdeb[i] = d[i]; run[i] = 0; end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic hold_for(input int n);
        for (int j = 0; j < n; j++) step(cur, en_cur, 1'b0);
    endtask

    // Monitor: compares one expected entry per clock, away from the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                total++;
                if (press_out !== x.p) begin
                    bad++;
                    $display("FAIL press cyc=%0d got=%b exp=%b", x.cyc, press_out, x.p);
                end
                total++;
                if (release_out !== x.r) begin
                    bad++;
                    $display("FAIL release cyc=%0d got=%b exp=%b", x.cyc, release_out, x.r);
                end
                total++;
                if (held_out !== x.h) begin
                    bad++;
                    $display("FAIL held cyc=%0d got=%b exp=%b", x.cyc, held_out, x.h);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] bounce;
        Reset = 1'b1; data = '0; repeat_en = 1'b0;
        cur = '0; en_cur = 1'b0;
        model_clear();

        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        hold_for(3);

        // Clean press/release on channel 0, repeat disabled.
        cur[0] = 1'b1; hold_for(20);
        cur[0] = 1'b0; hold_for(10);

        // Bounce on channel 1: 1,1,0,1,1,0,1,1,1 then held.
        bounce = '0;
        for (int j = 0; j < 9; j++) begin
            bounce[1] = ((j == 2) || (j == 5)) ? 1'b0 : 1'b1;
            step(bounce, en_cur, 1'b0);
        end
        cur[1] = 1'b1; hold_for(8);
        cur[1] = 1'b0; hold_for(10);

        // Auto-repeat on channel 2, then release timed onto a repeat expiry.
        en_cur = 1'b1;
        cur[2] = 1'b1; hold_for(30);
        for (int j = 0; j < 20 && (k + 1) != nrpt[2] - D; j++) step(cur, en_cur, 1'b0);
        cur[2] = 1'b0; hold_for(10);

        // Repeat re-enable mid-hold restarts the full delay.
        cur[2] = 1'b1; hold_for(16);
        en_cur = 1'b0; hold_for(3);
        en_cur = 1'b1; hold_for(16);
        cur[2] = 1'b0; hold_for(8);

        // All channels together, then only channel 0 releases.
        cur = '1; hold_for(12);
        cur[0] = 1'b0; hold_for(8);
        cur = '0; hold_for(8);

        // Reset mid-hold on channel 3 with the key still down.
        cur[3] = 1'b1; hold_for(14);
        step(cur, en_cur, 1'b1);
        hold_for(16);
        cur[3] = 1'b0; hold_for(8);

        // Randomised phase: level runs of varying length, occasional enable
        // toggles and rare resets.
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(5) == 0) cur[i] = ~cur[i];
            if ($urandom_range(39) == 0) en_cur = ~en_cur;
            step(cur, en_cur, ($urandom_range(149) == 0));
        end
        cur = '0; hold_for(10);

        for (int j = 0; j < 10 && q.size() != 0; j++) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
